// File: rtl/act_stream.sv
// Two-stage valid/ready activation pipeline: LANES FP32 values per beat, per-beat mode.
// Optional macro ACT_STREAM_STATS_EN adds clip_count/clear_stats statistics ports.
module act_stream #(
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*32-1:0]  in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*32-1:0]  out_data
`ifdef ACT_STREAM_STATS_EN
    ,
    output logic [31:0]          clip_count,
    input  logic                 clear_stats
`endif
);

    localparam logic [1:0] MODE_RELU  = 2'd0;
    localparam logic [1:0] MODE_LEAKY = 2'd1;
    localparam logic [1:0] MODE_RELU6 = 2'd2;
    localparam logic [7:0] LS         = 8'(LEAK_SHIFT);

    // Handshake: a beat transfers on a rising edge where valid && ready;
    // valid never waits on ready, ready may depend on downstream ready.

    function automatic logic [31:0] act_lane(input logic [31:0] x, input logic [1:0] mode);
        logic [31:0] res;
        res = x;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin
            res = 32'h7FC00000;
        end else if (x[30:23] == 8'd0) begin
            if (mode != 2'd3) res = 32'h0;
        end else begin
            case (mode)
                MODE_RELU:  if (x[31]) res = 32'h0;
                MODE_LEAKY: begin
                    // -inf keeps its all-ones exponent rather than being scaled
                    if (x[31] && x[30:23] != 8'hFF) begin
                        if (x[30:23] > LS) res = {1'b1, x[30:23] - LS, x[22:0]};
                        else               res = 32'h0;
                    end
                end
                MODE_RELU6: begin
                    if (x[31])                          res = 32'h0;
                    else if (x[30:0] > 31'h40C00000)    res = 32'h40C00000;
                end
                default: ;
            endcase
        end
        return res;
    endfunction

    logic                s1_full;
    logic [LANES*32-1:0] s1_data;
    logic [1:0]          s1_mode;
    logic [LANES*32-1:0] s1_result;
    logic                s2_open;
    logic                s1_advance;
    logic                in_fire;

    assign s2_open    = !out_valid || out_ready;
    assign s1_advance = s1_full && s2_open;
    assign in_ready   = !s1_full || s2_open;
    assign in_fire    = in_valid && in_ready;

    always_comb begin
        s1_result = '0;
        for (int i = 0; i < LANES; i++) begin
            s1_result[32*i +: 32] = act_lane(s1_data[32*i +: 32], s1_mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full <= 1'b0;
            s1_data <= '0;
            s1_mode <= 2'd0;
        end else if (in_ready) begin
            s1_full <= in_valid;
            if (in_fire) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_open) begin
            out_valid <= s1_full;
            if (s1_full) out_data <= s1_result;
        end
    end

`ifdef ACT_STREAM_STATS_EN
    // A lane is clipped only when a rule forced it to 0 or 6.0 from a normal/inf input.
    function automatic logic lane_clipped(input logic [31:0] x, input logic [1:0] mode);
        logic c;
        c = 1'b0;
        if (!(x[30:23] == 8'hFF && x[22:0] != 23'd0) && x[30:23] != 8'd0) begin
            case (mode)
                MODE_RELU:  c = x[31];
                MODE_LEAKY: c = x[31] && (x[30:23] <= LS);
                MODE_RELU6: c = x[31] || (x[30:0] > 31'h40C00000);
                default:    c = 1'b0;
            endcase
        end
        return c;
    endfunction

    logic [4:0]  clip_sum;
    logic [32:0] count_sum;

    always_comb begin
        clip_sum = 5'd0;
        for (int i = 0; i < LANES; i++) begin
            clip_sum = clip_sum + 5'(lane_clipped(s1_data[32*i +: 32], s1_mode));
        end
        count_sum = {1'b0, clip_count} + {28'd0, clip_sum};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count <= 32'd0;
        end else if (clear_stats) begin
            clip_count <= 32'd0;
        end else if (s1_advance) begin
            clip_count <= count_sum[32] ? 32'hFFFFFFFF : count_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_act_stream.sv
// Directed bench for act_stream: lane-rule model plus scoreboard queue checked every cycle.
`timescale 1ns/1ps
module tb_act_stream;
    localparam int LANES = 4;
    localparam int LS    = 3;
    localparam int W     = LANES*32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef ACT_STREAM_STATS_EN
    logic [31:0]  clip_count;
    logic         clear_stats;
`endif

    always #5 clk = ~clk;

    act_stream #(.LANES(LANES), .LEAK_SHIFT(LS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ACT_STREAM_STATS_EN
        , .clip_count(clip_count), .clear_stats(clear_stats)
`endif
    );

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int n_acc  = 0;
    int n_out  = 0;
    bit drv_done;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Value-class view of each lane: NaN, identity, tiny, then the mode rule.
    function automatic logic [31:0] model_lane(input logic [31:0] x, input logic [1:0] mode);
        bit neg;
        bit nan;
        bit inf;
        int ex;
        neg = x[31];
        ex  = int'(x[30:23]);
        nan = (ex == 255) && (x[22:0] != 0);
        inf = (ex == 255) && !nan;
        if (nan) return 32'h7FC00000;
        if (mode == 2'd3) return x;
        if (ex == 0) return 32'h0;
        case (mode)
            2'd0: return neg ? 32'h0 : x;
            2'd1: begin
                if (!neg || inf) return x;
                if (ex - LS < 1) return 32'h0;
                return {1'b1, 8'(ex - LS), x[22:0]};
            end
            default: begin
                if (neg) return 32'h0;
                return (x[30:0] > 31'h40C00000) ? 32'h40C00000 : x;
            end
        endcase
    endfunction

    function automatic logic [W-1:0] model_beat(input logic [W-1:0] d, input logic [1:0] mode);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[32*i +: 32] = model_lane(d[32*i +: 32], mode);
        return r;
    endfunction

    // Scoreboard: pops on output handshakes, pushes on input handshakes, checks stall holds.
    bit           stalled = 0;
    logic [W-1:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stalled = 0;
        end else begin
            if (stalled) begin
                check("hold_valid", W'(out_valid), W'(1));
                check("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got %h expected none", out_data);
                end else begin
                    check("stream", out_data, exp_q.pop_front());
                end
                n_out++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_beat(in_data, in_mode));
                n_acc++;
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [1:0] m);
        int  budget;
        bit  ok;
        budget   = 0;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
            budget++;
            if (budget > 200) begin
                checks++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
                break;
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain", W'(exp_q.size()), W'(0));
    endtask

    function automatic logic [W-1:0] beat4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    logic [31:0] vals[12];
    logic [1:0]  ready_pat[20];
    int          base;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        vals = '{32'hbf800000, 32'h3f800000, 32'h80000000, 32'h7FC00001, 32'h81000000, 32'hff800000,
                 32'h41000000, 32'h40A00000, 32'h7f800000, 32'hc0000000, 32'h40C00000, 32'h00000001};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; out_ready = 1'b1;
`ifdef ACT_STREAM_STATS_EN
        clear_stats = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_out_data", out_data, W'(0));
        check("reset_in_ready", W'(in_ready), W'(1));
`ifdef ACT_STREAM_STATS_EN
        check("reset_clip_count", W'(clip_count), W'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed lane results pin the model.
        check("pin_leaky_neg", W'(model_lane(32'hbf800000, 2'd1)), W'(32'hbe000000));
        check("pin_leaky_flush", W'(model_lane(32'h81000000, 2'd1)), W'(32'h0));
        check("pin_leaky_ninf", W'(model_lane(32'hff800000, 2'd1)), W'(32'hff800000));
        check("pin_relu6_8", W'(model_lane(32'h41000000, 2'd2)), W'(32'h40C00000));
        check("pin_relu6_5", W'(model_lane(32'h40A00000, 2'd2)), W'(32'h40A00000));
        check("pin_relu6_inf", W'(model_lane(32'h7f800000, 2'd2)), W'(32'h40C00000));
        check("pin_relu6_neg", W'(model_lane(32'hc0000000, 2'd2)), W'(32'h0));
        check("pin_ident_negzero", W'(model_lane(32'h80000000, 2'd3)), W'(32'h80000000));

        // ReLU beat: latency of exactly two cycles and literal result.
        @(posedge clk); #1;
        send(beat4(32'hbf800000, 32'h3f800000, 32'h80000000, 32'h7FC00001), 2'd0);
        check("latency_not_early", W'(out_valid), W'(0));
        @(posedge clk); #1;
        check("latency_valid", W'(out_valid), W'(1));
        check("relu_literal", out_data, beat4(32'h0, 32'h3f800000, 32'h0, 32'h7FC00000));
        wait_idle();

        // Mode switching on back-to-back beats.
        send(beat4(32'hbf800000, 32'h81000000, 32'hff800000, 32'h3f800000), 2'd1);
        send(beat4(32'h41000000, 32'h40A00000, 32'h7f800000, 32'hc0000000), 2'd2);
        send(beat4(32'h80000000, 32'h00000001, 32'h7FC00001, 32'hc0400000), 2'd3);
        for (int k = 0; k < 8; k++) begin
            send(beat4(vals[k % 12], vals[(k + 5) % 12], vals[(k + 7) % 12], vals[(k + 10) % 12]),
                 2'(k % 4));
        end
        wait_idle();

        // Backpressure: two beats absorbed, then release drains five beats on consecutive cycles.
        out_ready = 1'b0;
        drv_done  = 0;
        base      = n_acc;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    send(beat4(vals[(k + 1) % 12], vals[(k + 3) % 12], vals[(k + 6) % 12], vals[(k + 9) % 12]),
                         2'((k + 2) % 4));
                end
                drv_done = 1;
            end
        join_none
        repeat (6) @(posedge clk);
        #1;
        check("bp_in_ready_low", W'(in_ready), W'(0));
        check("bp_absorbed", W'(n_acc - base), W'(2));
        out_ready = 1'b1;
        base = n_out;
        repeat (5) @(posedge clk);
        #1;
        check("bp_drain_5", W'(n_out - base), W'(5));
        check("bp_drained_valid", W'(out_valid), W'(0));
        for (int t = 0; t < 50 && !drv_done; t++) @(posedge clk);
        wait_idle();

        // Irregular downstream ready with a continuous input stream.
        ready_pat = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1,
                      2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
        drv_done = 0;
        fork
            begin
                for (int k = 0; k < 7; k++) begin
                    send(beat4(vals[(k + 2) % 12], vals[(k + 4) % 12], vals[(k + 8) % 12], vals[(k + 11) % 12]),
                         2'(k % 4));
                end
                drv_done = 1;
            end
        join_none
        for (int t = 0; t < 20; t++) begin
            out_ready = ready_pat[t][0];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int t = 0; t < 50 && !drv_done; t++) @(posedge clk);
        wait_idle();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(beat4(32'h3f800000, 32'h40A00000, 32'h41000000, 32'hbf800000), 2'd0);
        send(beat4(32'h3f800000, 32'h40A00000, 32'h41000000, 32'hbf800000), 2'd2);
        #2;
        check("pre_reset_valid", W'(out_valid), W'(1));
        rst_n = 1'b0;
        #1;
        check("reset_async_valid", W'(out_valid), W'(0));
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
            check("post_reset_no_stale", W'(out_valid), W'(0));
            check("post_reset_in_ready", W'(in_ready), W'(1));
        end

`ifdef ACT_STREAM_STATS_EN
        send(beat4(32'hbf800000, 32'h3f800000, 32'hc0000000, 32'h00000000), 2'd0);
        wait_idle();
        check("clip_count_relu", W'(clip_count), W'(2));
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        check("clip_count_clear", W'(clip_count), W'(0));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
